dendritic_tdm_scheduler: RTL and testbench
==========================================

// Module: dendritic_tdm_scheduler
// PURPOSE
// Time-multiplexes ONE shared 18x18 signed multiplier across NUM_CH two-compartment dendritic channels (L2/3, L5a, L5b).
// On each clk_en tick it samples every channel's inputs and steps through the channels sequentially, 5 multiplies per channel.
// Per-channel state (apical_depot, ca_state) lives in internal register arrays.
// All channel outputs are published together with a one-cycle out_valid strobe.
// Sits between the layer input mixers and the oscillators, and replaces per-layer dendritic multiplier banks.
// PARAMETERS
// WIDTH   18  sample width, signed Q4.14
// FRAC    14  fractional bits
// NUM_CH  3   channel count (>=1)
// CH_W    2   channel index width, >= clog2(NUM_CH)
// PORTS
// clk              in   1              clock
// rst              in   1              synchronous, active-high reset
// clk_en           in   1              4 kHz update tick, 1-cycle pulse
// basal_in         in   NUM_CH*WIDTH   per-channel feedforward; ch i at [i*WIDTH +: WIDTH]
// apical_in        in   NUM_CH*WIDTH   per-channel feedback
// apical_gain      in   NUM_CH*WIDTH   per-channel L1 gain
// ca_threshold     in   WIDTH          shared Ca2+ threshold
// dendritic_out    out  NUM_CH*WIDTH   per-channel output, registered
// ca_spike_active  out  NUM_CH         per-channel: clamp(ca_state) > 4096
// bac_active       out  NUM_CH         per-channel BAC coincidence flag
// out_valid        out  1              1-cycle strobe when the outputs update
// busy             out  1              sequence in progress
// overrun          out  1              sticky: a tick arrived while busy
// BEHAVIOUR
// - Reset: all outputs 0, all depot/ca state 0, FSM = IDLE. Reset mid-sequence aborts the sequence; there is no partial publish.
// - FSM states: IDLE -> (clk_en) LATCH -> per channel GAIN, CABLE, CA, APC, BAC -> next channel or PUBLISH -> IDLE.
// - LATCH happens in the tick cycle: all inputs are copied to shadow registers. busy goes high the next cycle.
// - Timing: ch c occupies cycles 1+5c .. 5+5c after the tick.
//   PUBLISH is at cycle 5*NUM_CH+1 (16 for NUM_CH=3): outputs and flags update, and out_valid=1 for exactly that cycle.
//   busy drops in the same cycle.
// - A tick in any state other than IDLE is ignored (the sequence is not restarted) and sets overrun=1. Only rst clears overrun.
// - A tick in the PUBLISH cycle counts as busy and is ignored.
// - Arithmetic:
//   mul(a,b) = low WIDTH bits of ((2*WIDTH-bit signed a*b) >>> FRAC).
//   All adds and subtracts wrap at WIDTH bits.
//   d0 and c0 are the channel's state values before this tick's update.
//   GAIN:  s  = mul(apical, gain)
//   CABLE: d1 = d0 + mul(s - d0, 410)
//   CA:    tgt = (d0 > ca_threshold) ? 16384 : 0   [signed compare, uses OLD depot]
//          c1 = c0 + mul(tgt - c0, 137)
//   APC:   cc = (c0 < 0) ? 0 : c0   [OLD ca]
//          comb = basal + mul(cc, 4096)
//   BAC:   bac = (basal > 4096 || basal < -4096) && cc > 4096
//          out = mul(comb, bac ? 24576 : 16384)
//          ca_spike_active = cc > 4096
// - Write-back: d1 and c1 are written in that channel's BAC cycle. out, bac and spike are held in staging registers until PUBLISH.
// - The shared multiplier is used exactly once per cycle in GAIN..BAC and is idle otherwise.
// - Input changes after the tick have no effect until the next tick.
// TESTING
// T1 Reset: assert rst for 3 cycles.
//    -> all outputs 0; busy=0; overrun=0.
// T2 Pass-through: basal0=8192, basal1=-8192, all apical=0; one tick.
//    -> out_valid at cycle 16 only; out0=8192; out1=-8192; all flags 0.
// T3 Cable: ch2 apical=16384, gain=16384, thr=131071.
//    -> after tick 1, internal depot2=410.
//    -> after tick 2, depot2=809.
//    -> spike stays 0.
// T4 Ca/BAC: ch0 apical=16384, gain=16384, thr=0, basal0=8192.
//    -> ca rises by 0 on tick 1 (depot was 0), then by 137 on tick 2.
//    -> spike0 and bac0 assert on the first tick whose old ca exceeds 4096.
//    -> out0 = mul(8192+mul(cc,4096), 24576).
// T5 Overrun: tick, then a second tick at cycle 3.
//    -> second tick is ignored; publish still at cycle 16; overrun=1 until rst.
// T6 Reset at cycle 8 mid-sequence.
//    -> no out_valid pulse; state zeroed.
//    -> the next tick behaves as if from power-on (T2 values reproduce).

Source files
------------

// File: rtl/dendritic_tdm_scheduler.sv
// dendritic_tdm_scheduler: one shared multiplier stepping NUM_CH dendritic channels per tick
module dendritic_tdm_scheduler #(
  parameter int WIDTH = 18,
  parameter int FRAC = 14,
  parameter int NUM_CH = 3,
  parameter int CH_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic [NUM_CH*WIDTH-1:0]  basal_in,
  input  logic [NUM_CH*WIDTH-1:0]  apical_in,
  input  logic [NUM_CH*WIDTH-1:0]  apical_gain,
  input  logic [WIDTH-1:0]         ca_threshold,
  output logic [NUM_CH*WIDTH-1:0]  dendritic_out,
  output logic [NUM_CH-1:0]        ca_spike_active,
  output logic [NUM_CH-1:0]        bac_active,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);
  localparam logic signed [WIDTH-1:0] K_ONE = WIDTH'(16384);
  localparam logic signed [WIDTH-1:0] K_BAC = WIDTH'(24576);
  localparam logic signed [WIDTH-1:0] K_CABLE = WIDTH'(410);
  localparam logic signed [WIDTH-1:0] K_CA = WIDTH'(137);
  localparam logic signed [WIDTH-1:0] K_QTR = WIDTH'(4096);
  localparam logic signed [WIDTH-1:0] K_NQTR = -WIDTH'(4096);
  typedef enum logic [2:0] {IDLE, GAIN, CABLE, CA, APC, BAC, PUBLISH} state_t;
  state_t state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [NUM_CH*WIDTH-1:0] basal_q, basal_d, apical_q, apical_d, gain_q, gain_d;
  logic [NUM_CH*WIDTH-1:0] depot_q, depot_d, ca_q, ca_d;
  logic [NUM_CH*WIDTH-1:0] stage_out_q, stage_out_d, out_q, out_d;
  logic [NUM_CH-1:0] stage_bac_q, stage_bac_d, stage_spk_q, stage_spk_d;
  logic [NUM_CH-1:0] bac_q, bac_d, spk_q, spk_d;
  logic signed [WIDTH-1:0] thr_q, thr_d, s_q, s_d, d1_q, d1_d, c1_q, c1_d, comb_q, comb_d;
  logic out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic signed [WIDTH-1:0] basal, apical, gain, d0, c0, cc, tgt, mul_a, mul_b, mul_r;
  logic signed [2*WIDTH-1:0] prod;
  logic bac, last, unused_prod;
  assign prod = mul_a * mul_b;
  assign unused_prod = ^{prod[FRAC-1:0], prod[2*WIDTH-1:FRAC+WIDTH]};
  assign last = ch_q == CH_W'(NUM_CH - 1);
  assign dendritic_out = out_q;
  assign ca_spike_active = spk_q;
  assign bac_active = bac_q;
  assign out_valid = out_valid_q;
  assign overrun = overrun_q;
  assign busy = state_q != IDLE && state_q != PUBLISH;
  always_comb begin
    basal = basal_q[ch_q*WIDTH +: WIDTH];
    apical = apical_q[ch_q*WIDTH +: WIDTH];
    gain = gain_q[ch_q*WIDTH +: WIDTH];
    d0 = depot_q[ch_q*WIDTH +: WIDTH];
    c0 = ca_q[ch_q*WIDTH +: WIDTH];
    cc = c0 < 0 ? '0 : c0;
    tgt = d0 > thr_q ? K_ONE : '0;
    bac = (basal > K_QTR || basal < K_NQTR) && cc > K_QTR;
    mul_a = state_q == GAIN  ? apical :
            state_q == CABLE ? s_q - d0 :
            state_q == CA    ? tgt - c0 :
            state_q == APC   ? cc :
            state_q == BAC   ? comb_q : '0;
    mul_b = state_q == GAIN  ? gain :
            state_q == CABLE ? K_CABLE :
            state_q == CA    ? K_CA :
            state_q == APC   ? K_QTR :
            state_q == BAC   ? (bac ? K_BAC : K_ONE) : '0;
    mul_r = prod[FRAC +: WIDTH];
  end
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    basal_d = basal_q;
    apical_d = apical_q;
    gain_d = gain_q;
    thr_d = thr_q;
    depot_d = depot_q;
    ca_d = ca_q;
    s_d = s_q;
    d1_d = d1_q;
    c1_d = c1_q;
    comb_d = comb_q;
    stage_out_d = stage_out_q;
    stage_bac_d = stage_bac_q;
    stage_spk_d = stage_spk_q;
    out_d = out_q;
    bac_d = bac_q;
    spk_d = spk_q;
    out_valid_d = 1'b0;
    overrun_d = overrun_q | (clk_en && state_q != IDLE);
    unique case (state_q)
      IDLE: if (clk_en) begin
        basal_d = basal_in;
        apical_d = apical_in;
        gain_d = apical_gain;
        thr_d = ca_threshold;
        ch_d = '0;
        state_d = GAIN;
      end
      GAIN: begin
        s_d = mul_r;
        state_d = CABLE;
      end
      CABLE: begin
        d1_d = d0 + mul_r;
        state_d = CA;
      end
      CA: begin
        c1_d = c0 + mul_r;
        state_d = APC;
      end
      APC: begin
        comb_d = basal + mul_r;
        state_d = BAC;
      end
      BAC: begin
        depot_d[ch_q*WIDTH +: WIDTH] = d1_q;
        ca_d[ch_q*WIDTH +: WIDTH] = c1_q;
        stage_out_d[ch_q*WIDTH +: WIDTH] = mul_r;
        stage_bac_d[ch_q] = bac;
        stage_spk_d[ch_q] = cc > K_QTR;
        out_d = last ? stage_out_d : out_q;
        bac_d = last ? stage_bac_d : bac_q;
        spk_d = last ? stage_spk_d : spk_q;
        out_valid_d = last;
        ch_d = last ? ch_q : ch_q + 1'b1;
        state_d = last ? PUBLISH : GAIN;
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      basal_q <= '0;
      apical_q <= '0;
      gain_q <= '0;
      thr_q <= '0;
      depot_q <= '0;
      ca_q <= '0;
      s_q <= '0;
      d1_q <= '0;
      c1_q <= '0;
      comb_q <= '0;
      stage_out_q <= '0;
      stage_bac_q <= '0;
      stage_spk_q <= '0;
      out_q <= '0;
      bac_q <= '0;
      spk_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      basal_q <= basal_d;
      apical_q <= apical_d;
      gain_q <= gain_d;
      thr_q <= thr_d;
      depot_q <= depot_d;
      ca_q <= ca_d;
      s_q <= s_d;
      d1_q <= d1_d;
      c1_q <= c1_d;
      comb_q <= comb_d;
      stage_out_q <= stage_out_d;
      stage_bac_q <= stage_bac_d;
      stage_spk_q <= stage_spk_d;
      out_q <= out_d;
      bac_q <= bac_d;
      spk_q <= spk_d;
      out_valid_q <= out_valid_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_dendritic_tdm_scheduler.sv
// tb_dendritic_tdm_scheduler: scoreboard bench for the dendritic TDM scheduler
module tb_dendritic_tdm_scheduler;
  localparam int W = 18;
  localparam int N = 3;
  localparam logic [W-1:0] NEG8192 = -18'sd8192;
  typedef struct {
    logic [N*W-1:0] out;
    logic [N-1:0] spk;
    logic [N-1:0] bac;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic signed [W-1:0] b[N], a[N], g[N], thr;
  logic [N*W-1:0] basal_in, apical_in, apical_gain, dendritic_out;
  logic [N-1:0] ca_spike_active, bac_active;
  logic out_valid, busy, overrun;
  logic signed [W-1:0] m_depot[N], m_ca[N];
  exp_t sb[$];
  int checks = 0, errors = 0, edge_cnt = 0, tick_edge = 0, n_valid = 0;
  assign basal_in = {b[2], b[1], b[0]};
  assign apical_in = {a[2], a[1], a[0]};
  assign apical_gain = {g[2], g[1], g[0]};
  dendritic_tdm_scheduler dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .basal_in(basal_in), .apical_in(apical_in), .apical_gain(apical_gain),
    .ca_threshold(thr), .dendritic_out(dendritic_out),
    .ca_spike_active(ca_spike_active), .bac_active(bac_active),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic signed [W-1:0] mul(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    logic signed [2*W-1:0] p;
    p = x * y;
    p = p >>> 14;
    return p[W-1:0];
  endfunction
  task automatic model_push();
    exp_t e;
    logic signed [W-1:0] s, d0, c0, cc, comb;
    logic bf;
    e.out = '0;
    e.spk = '0;
    e.bac = '0;
    for (int i = 0; i < N; i++) begin
      s = mul(a[i], g[i]);
      d0 = m_depot[i];
      c0 = m_ca[i];
      cc = (c0 < 0) ? '0 : c0;
      comb = b[i] + mul(cc, 18'sd4096);
      bf = (b[i] > 4096 || b[i] < -4096) && cc > 4096;
      e.out[i*W +: W] = mul(comb, bf ? 18'sd24576 : 18'sd16384);
      e.spk[i] = cc > 4096;
      e.bac[i] = bf;
      m_depot[i] = d0 + mul(s - d0, 18'sd410);
      m_ca[i] = c0 + mul((d0 > thr ? 18'sd16384 : 18'sd0) - c0, 18'sd137);
    end
    sb.push_back(e);
  endtask
  task automatic zero_inputs();
    for (int i = 0; i < N; i++) begin
      b[i] = '0;
      a[i] = '0;
      g[i] = '0;
    end
    thr = '0;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    clk_en = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      m_depot[i] = '0;
      m_ca[i] = '0;
    end
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic tick(input bit accepted);
    @(negedge clk);
    if (accepted) model_push();
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    if (accepted) tick_edge = edge_cnt;
  endtask
  task automatic wait_publish();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("publish_timeout", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      n_valid++;
      chk("publish_cycle", edge_cnt - tick_edge + 1, 16);
      chk("busy_at_publish", busy, 0);
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out", dendritic_out, e.out);
        chk("spike", ca_spike_active, e.spk);
        chk("bac", bac_active, e.bac);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int nv;
    bit seen;
    exp_t last_e;
    zero_inputs();
    do_reset(3);
    chk("rst_out", dendritic_out, 0);
    chk("rst_spike", ca_spike_active, 0);
    chk("rst_bac", bac_active, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    b[0] = 18'sd8192;
    b[1] = -18'sd8192;
    nv = n_valid;
    tick(1);
    chk("t2_busy", busy, 1);
    wait_publish();
    chk("t2_out0", dendritic_out[0 +: W], 8192);
    chk("t2_out1", dendritic_out[W +: W], NEG8192);
    chk("t2_flags", {ca_spike_active, bac_active}, 0);
    chk("t2_valid_count", n_valid - nv, 1);
    do_reset(1);
    zero_inputs();
    a[2] = 18'sd16384;
    g[2] = 18'sd16384;
    thr = 18'sd131071;
    tick(1);
    wait_publish();
    chk("t3_depot_tick1", dut.depot_q[2*W +: W], 410);
    tick(1);
    wait_publish();
    chk("t3_depot_tick2", dut.depot_q[2*W +: W], 809);
    chk("t3_spike2", ca_spike_active[2], 0);
    do_reset(1);
    zero_inputs();
    a[0] = 18'sd16384;
    g[0] = 18'sd16384;
    b[0] = 18'sd8192;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick(1);
      last_e = sb[$];
      wait_publish();
      if (k == 0) chk("t4_ca_tick1", dut.ca_q[0 +: W], 0);
      if (k == 1) chk("t4_ca_tick2", dut.ca_q[0 +: W], 137);
      if (last_e.spk[0]) begin
        seen = 1'b1;
        chk("t4_spike0", ca_spike_active[0], 1);
        chk("t4_bac0", bac_active[0], 1);
      end
    end
    chk("t4_spike_reached", seen, 1);
    do_reset(1);
    zero_inputs();
    b[0] = 18'sd8192;
    b[1] = -18'sd8192;
    nv = n_valid;
    tick(1);
    @(negedge clk);
    tick(0);
    chk("t5_overrun_set", overrun, 1);
    wait_publish();
    repeat (20) @(negedge clk);
    chk("t5_single_publish", n_valid - nv, 1);
    chk("t5_overrun_sticky", overrun, 1);
    do_reset(1);
    chk("t5_overrun_cleared", overrun, 0);
    zero_inputs();
    a[2] = 18'sd16384;
    g[2] = 18'sd16384;
    thr = 18'sd131071;
    tick(1);
    wait_publish();
    b[0] = 18'sd8192;
    tick(1);
    repeat (7) @(negedge clk);
    do_reset(1);
    nv = n_valid;
    repeat (25) @(negedge clk);
    chk("t6_no_valid", n_valid - nv, 0);
    chk("t6_depot_zero", dut.depot_q, 0);
    chk("t6_out_zero", dendritic_out, 0);
    chk("t6_busy", busy, 0);
    zero_inputs();
    b[0] = 18'sd8192;
    b[1] = -18'sd8192;
    tick(1);
    wait_publish();
    chk("t6_out0", dendritic_out[0 +: W], 8192);
    chk("t6_out1", dendritic_out[W +: W], NEG8192);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
